// File: rtl/mcs4_pc_stack.sv
// rtl/mcs4_pc_stack.sv - MCS-4 program counter and circular return stack (optional bank select: MCS4_ROM_BANK_SEL_EN)
module mcs4_pc_stack #(
    parameter int ADDR_W      = 12,
    parameter int PAGE_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CALL_LEN    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   op_valid,
    input  logic [2:0]                             op,
    input  logic [ADDR_W-1:0]                      target,
    input  logic                                   err_clr,
    output logic [ADDR_W-1:0]                      pc,
    output logic                                   bank,
    output logic [$clog2(STACK_DEPTH+1)-1:0]       depth,
    output logic                                   full,
    output logic                                   empty,
    output logic                                   ovf,
    output logic                                   unf
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);
`ifdef MCS4_ROM_BANK_SEL_EN
    localparam int EW = ADDR_W + 1;
`else
    localparam int EW = ADDR_W;
`endif

    localparam logic [2:0] OP_INC       = 3'd1;
    localparam logic [2:0] OP_JUMP      = 3'd2;
    localparam logic [2:0] OP_JUMP_PAGE = 3'd3;
    localparam logic [2:0] OP_CALL      = 3'd4;
    localparam logic [2:0] OP_RET       = 3'd5;
`ifdef MCS4_ROM_BANK_SEL_EN
    localparam logic [2:0] OP_SB0       = 3'd6;
    localparam logic [2:0] OP_SB1       = 3'd7;
`endif

    logic [EW-1:0]     stack [STACK_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     ptr_inc;
    logic [PW-1:0]     ptr_dec;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_ret;
    logic [ADDR_W-1:0] pc_page;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     pop_entry;

    // Depth need not be a power of two, so the pointer wraps explicitly.
    assign ptr_inc  = (wr_ptr == PW'(STACK_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign ptr_dec  = (wr_ptr == '0) ? PW'(STACK_DEPTH - 1) : wr_ptr - 1'b1;
    assign pc_plus1 = pc + 1'b1;
    assign pc_ret   = pc + ADDR_W'(CALL_LEN);
    assign pc_page  = {pc_plus1[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]};
    assign pop_entry = stack[ptr_dec];

`ifdef MCS4_ROM_BANK_SEL_EN
    logic bank_r;
    logic bank_pend;
    assign bank       = bank_r;
    assign push_entry = {bank_r, pc_ret};
`else
    assign bank       = 1'b0;
    assign push_entry = pc_ret;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= '0;
            depth  <= '0;
            wr_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
`ifdef MCS4_ROM_BANK_SEL_EN
            bank_r    <= 1'b0;
            bank_pend <= 1'b0;
`endif
        end else begin
            // Clear first so a flag raised by this cycle's op wins.
            if (err_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (op_valid) begin
                case (op)
                    OP_INC: pc <= pc_plus1;
                    OP_JUMP: begin
                        pc <= target;
`ifdef MCS4_ROM_BANK_SEL_EN
                        bank_r <= bank_pend;
`endif
                    end
                    OP_JUMP_PAGE: begin
                        pc <= pc_page;
`ifdef MCS4_ROM_BANK_SEL_EN
                        bank_r <= bank_pend;
`endif
                    end
                    OP_CALL: begin
                        stack[wr_ptr] <= push_entry;
                        wr_ptr        <= ptr_inc;
                        pc            <= target;
`ifdef MCS4_ROM_BANK_SEL_EN
                        bank_r <= bank_pend;
`endif
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            depth <= depth + 1'b1;
                            full  <= (depth + 1'b1 == DW'(STACK_DEPTH));
                            empty <= 1'b0;
                        end
                    end
                    OP_RET: begin
                        wr_ptr <= ptr_dec;
                        pc     <= pop_entry[ADDR_W-1:0];
`ifdef MCS4_ROM_BANK_SEL_EN
                        bank_r <= pop_entry[ADDR_W];
`endif
                        if (empty) begin
                            unf <= 1'b1;
                        end else begin
                            depth <= depth - 1'b1;
                            empty <= (depth == DW'(1));
                            full  <= 1'b0;
                        end
                    end
`ifdef MCS4_ROM_BANK_SEL_EN
                    OP_SB0: bank_pend <= 1'b0;
                    OP_SB1: bank_pend <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mcs4_pc_stack.sv
// tb/tb_mcs4_pc_stack.sv - randomized and directed bench for mcs4_pc_stack against a behavioural model
module tb_mcs4_pc_stack;
    localparam int AW = 12;
    localparam int SD = 4;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [AW-1:0] target = '0;
    logic          err_clr = 1'b0;
    logic [AW-1:0] pc;
    logic          bank;
    logic [2:0]    depth;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;

    int tests = 0;
    int fails = 0;

    // Reference model state, plain integers.
    int m_pc, m_bank, m_pend, m_depth, m_ptr, m_ovf, m_unf;
    int m_stk [SD];

    mcs4_pc_stack #(.ADDR_W(AW), .PAGE_W(8), .STACK_DEPTH(SD), .CALL_LEN(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .target(target),
        .err_clr(err_clr), .pc(pc), .bank(bank), .depth(depth), .full(full),
        .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, int'(pc), m_pc);
        check({tag, ".bank"}, int'(bank), m_bank);
        check({tag, ".depth"}, int'(depth), m_depth);
        check({tag, ".full"}, int'(full), int'(m_depth == SD));
        check({tag, ".empty"}, int'(empty), int'(m_depth == 0));
        check({tag, ".ovf"}, int'(ovf), m_ovf);
        check({tag, ".unf"}, int'(unf), m_unf);
    endtask

    task automatic model_reset();
        m_pc = 0; m_bank = 0; m_pend = 0; m_depth = 0; m_ptr = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < SD; i++) m_stk[i] = 0;
    endtask

    task automatic model_step(input int v, input int o, input int t, input int clr);
        if (clr != 0) begin m_ovf = 0; m_unf = 0; end
        if (v == 0) return;
        case (o)
            1: m_pc = (m_pc + 1) % AMOD;
            2: begin m_pc = t; m_bank = m_pend; end
            3: begin m_pc = (((m_pc + 1) % AMOD) / 256) * 256 + (t % 256); m_bank = m_pend; end
            4: begin
                m_stk[m_ptr] = m_bank * AMOD + (m_pc + 2) % AMOD;
                m_ptr = (m_ptr + 1) % SD;
                if (m_depth == SD) m_ovf = 1; else m_depth++;
                m_pc = t;
                m_bank = m_pend;
            end
            5: begin
                m_ptr = (m_ptr + SD - 1) % SD;
                m_pc = m_stk[m_ptr] % AMOD;
`ifdef MCS4_ROM_BANK_SEL_EN
                m_bank = m_stk[m_ptr] / AMOD;
`endif
                if (m_depth == 0) m_unf = 1; else m_depth--;
            end
            6, 7: begin
`ifdef MCS4_ROM_BANK_SEL_EN
                m_pend = o - 6;
`endif
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input int v, input int o, input int t, input int clr, input string tag);
        @(negedge clk);
        op_valid = v[0];
        op = 3'(o);
        target = AW'(t);
        err_clr = clr[0];
        model_step(v, o, t, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        op_valid = 1'b1;
        op = 3'd4;
        target = AW'(12'h5A5);
        err_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
        op_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset("reset");

        for (int i = 0; i < AMOD; i++) do_op(1, 1, 0, 0, "inc");
        check("inc_wrap", int'(pc), 0);

        do_op(1, 2, 12'h0FF, 0, "jmp");
        do_op(1, 3, 12'h034, 0, "jp_next");
        check("jp_next_abs", int'(pc), 12'h134);
        do_op(1, 2, 12'h050, 0, "jmp");
        do_op(1, 3, 12'h034, 0, "jp_same");
        check("jp_same_abs", int'(pc), 12'h034);
        do_op(1, 2, 12'hFFF, 0, "jmp");
        do_op(1, 3, 12'h012, 0, "jp_top");
        check("jp_top_abs", int'(pc), 12'h012);

        do_reset("reset2");
        do_op(1, 2, 12'h100, 0, "jmp");
        do_op(1, 4, 12'h200, 0, "call1");
        do_op(1, 4, 12'h300, 0, "call2");
        check("call2_depth", int'(depth), 2);
        do_op(1, 5, 0, 0, "ret1");
        check("ret1_pc", int'(pc), 12'h202);
        do_op(1, 5, 0, 0, "ret2");
        check("ret2_pc", int'(pc), 12'h102);

        do_op(1, 2, 12'h010, 0, "jmp");
        for (int i = 1; i <= 5; i++) do_op(1, 4, 12'h010 * (i + 1), 0, "ovf_call");
        check("ovf_flag", int'(ovf), 1);
        check("ovf_full", int'(full), 1);
        for (int i = 0; i < 4; i++) begin
            do_op(1, 5, 0, 0, "ovf_ret");
            check("ovf_ret_pc", int'(pc), 12'h052 - 12'h010 * i);
        end
        do_op(1, 5, 0, 0, "unf_ret");
        check("unf_stale_pc", int'(pc), 12'h052);
        check("unf_flag", int'(unf), 1);
        do_op(1, 5, 0, 1, "unf_clr_set");
        check("unf_set_wins", int'(unf), 1);
        do_op(0, 5, 0, 1, "clr_only");
        check("clr_only_unf", int'(unf), 0);

`ifdef MCS4_ROM_BANK_SEL_EN
        do_reset("reset_bank");
        do_op(1, 7, 0, 0, "sb1");
        do_op(1, 1, 0, 0, "inc_bank");
        do_op(1, 2, 12'h010, 0, "jmp_bank");
        do_op(1, 4, 12'h020, 0, "call_bank");
        do_op(1, 6, 0, 0, "sb0");
        do_op(1, 2, 12'h030, 0, "jmp_bank0");
        do_op(1, 5, 0, 0, "ret_bank");
        check("ret_bank_pc", int'(pc), 12'h012);
        check("ret_bank_bank", int'(bank), 1);
`endif

        do_reset("reset3");
        for (int i = 0; i < 3; i++) do_op(1, 4, 12'h100 + i, 0, "pre_rst_call");
        do_reset("mid_reset");
        check("mid_reset_depth", int'(depth), 0);
        do_op(1, 5, 0, 0, "post_rst_ret");
        check("post_rst_pc", int'(pc), 0);
        check("post_rst_unf", int'(unf), 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
            end else begin
                do_op(($urandom_range(0, 9) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
                      int'($urandom_range(0, AMOD - 1)),
                      ($urandom_range(0, 9) == 0) ? 1 : 0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mcs4_pc_stack.md
Name: mcs4_pc_stack

Overview:
- Parametrised program-counter and subroutine-return-stack unit for the next-generation MCS-4 CPU core, replacing the fixed 4-level, silently wrapping address register.
- Sits between instruction decode and the A1-A3 address drive logic.
- Takes one decoded flow-control operation per instruction cycle and holds PC, ROM bank and stack state.
- Adds configurable depth, overflow/underflow reporting, occupancy outputs and optional i4040-style ROM bank select.

Parameters:
- ADDR_W, 12: PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- PAGE_W, 8: page-offset width; JUMP_PAGE replaces PC[PAGE_W-1:0].
- STACK_DEPTH, 4: number of return-address entries; any integer >=2 (8 for i4040 mode).
- CALL_LEN, 2: words skipped on return; CALL pushes PC+CALL_LEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- op_valid  in  1  qualifies op/target for this cycle.
- op  in  3  0 HOLD, 1 INC, 2 JUMP, 3 JUMP_PAGE, 4 CALL, 5 RET, 6 SB0, 7 SB1.
- target  in  ADDR_W  jump/call destination; JUMP_PAGE uses only [PAGE_W-1:0].
- err_clr  in  1  clears sticky ovf/unf.
- pc  out  ADDR_W  current program counter (registered).
- bank  out  1  current ROM bank (registered; constant 0 when feature absent).
- depth  out  $clog2(STACK_DEPTH+1)  valid stack entries.
- full  out  1  depth==STACK_DEPTH.
- empty  out  1  depth==0.
- ovf  out  1  sticky: CALL issued while full.
- unf  out  1  sticky: RET issued while empty.

Behaviour:
- Reset (rst==0 at edge): pc=0, bank=0, depth=0, wr_ptr=0, all stack entries=0, ovf=0, unf=0, full=0, empty=1. Reset dominates every other input.
- Latency: one cycle. Op sampled at edge N; pc/depth/flags reflect it after edge N. Outputs change only at edges.
- op_valid==0 or op==HOLD: no state change.
- INC: pc <= pc+1; 0xFFF -> 0x000 at ADDR_W=12.
- JUMP: pc <= target.
- JUMP_PAGE: pc <= {(pc+1)[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]}. At the last word of a page, the jump lands in the next page (pc=0x0FF, target=0x34 -> 0x134). Top page wraps to page 0.
- CALL:
  - Writes {bank, pc+CALL_LEN} to stack[wr_ptr]; wr_ptr <= wr_ptr+1 mod STACK_DEPTH; pc <= target.
  - Not full: depth+1.
  - Full: oldest entry overwritten (circular), depth stays STACK_DEPTH, ovf <= 1.
- RET:
  - wr_ptr <= wr_ptr-1 mod STACK_DEPTH; pc, bank <= stack[wr_ptr-1].
  - Not empty: depth-1.
  - Empty: still pops the circular slot (stale or reset content, deterministic), depth stays 0, unf <= 1.
- Stack storage is a circular buffer of STACK_DEPTH entries, each ADDR_W+1 bits. The pointer is the only index; no separate read pointer.
- err_clr: ovf/unf <= 0, unless the same cycle's op sets that flag, in which case set wins.
- full and empty are registered, consistent with depth after every edge.
- SB0/SB1: see Optional Feature. Without the feature they are ignored (HOLD).
- Reset asserted mid-sequence (e.g., between CALL and RET) discards all stack content. No partial update.

Optional Feature:
- Macro: MCS4_ROM_BANK_SEL_EN.
- Defined:
  - SB0 sets pending bank 0, SB1 sets pending bank 1.
  - Pending bank is copied to bank on the next JUMP, JUMP_PAGE or CALL (i4040 DB0/DB1 semantics). INC does not change bank.
  - CALL pushes the current bank; RET restores bank from the popped entry.
  - Pending bank resets to 0.
- Undefined:
  - No pending-bank register; bank tied to 0.
  - Stack entries are ADDR_W bits.
  - SB0/SB1 behave as HOLD.

Test Plan:
- Reset, then 4096 INC -> pc steps 0x000..0xFFF, wraps to 0x000; depth=0, empty=1 throughout.
- pc=0x0FF, JUMP_PAGE target=0x34 -> pc=0x134. pc=0x050, JUMP_PAGE target=0x34 -> pc=0x034.
- STACK_DEPTH=4, pc=0x100: CALL 0x200, CALL 0x300, RET, RET -> pc 0x200, 0x300, 0x202, 0x102. depth goes 1,2,1,0; ovf=unf=0.
- STACK_DEPTH=4: five CALLs (each pushing distinct returns R1..R5) -> full=1, ovf=1, depth=4. Four RETs -> R5, R4, R3, R2. Fifth RET -> unf=1, pc=R5 (stale slot). err_clr asserted together with a further RET on empty -> unf remains 1.
- With MCS4_ROM_BANK_SEL_EN: SB1, INC (bank stays 0), JUMP 0x010 (bank=1), CALL 0x020, SB0, JUMP 0x030 (bank=0), RET -> pc=0x012, bank=1.
- rst low for one cycle after three CALLs -> pc=0, depth=0, empty=1, flags 0. Next RET sets unf and returns pc=0.
